// File: rtl/ps2_scan_decoder.sv
// PS/2 scan-code decoder: pops bytes from the receiver FIFO, folds E0/F0 prefixes,
// tracks the held key, maps makes to ASCII and counts presses. Optional macro: PS2_SHIFT_EN.
module ps2_scan_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [7:0]       kbd_data,
    input  logic             kbd_ready,
    output logic             kbd_nextdata_n,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic [7:0]       key_ascii,
    output logic             key_held,
    output logic             key_event,
    output logic             key_break,
    output logic [CNT_W-1:0] press_count
);

    typedef enum logic [1:0] {IDLE, POP, SETTLE} state_t;

    state_t           state_q, state_d;
    logic [7:0]       byte_q, byte_d;
    logic             ext_q, ext_d;
    logic             brk_q, brk_d;
    logic [7:0]       key_code_q, key_code_d;
    logic             key_ext_q, key_ext_d;
    logic [7:0]       key_ascii_q, key_ascii_d;
    logic             key_held_q, key_held_d;
    logic             key_event_q, key_event_d;
    logic             key_break_q, key_break_d;
    logic [CNT_W-1:0] press_count_q, press_count_d;
    logic [7:0]       held_code_q, held_code_d;
    logic             held_ext_q, held_ext_d;
    logic             same_key;
    logic             shift_any;

`ifdef PS2_SHIFT_EN
    logic shift_l_q, shift_l_d;
    logic shift_r_q, shift_r_d;
    assign shift_any = shift_l_q | shift_r_q;
`else
    assign shift_any = 1'b0;
`endif

    // Set-2 make code to ASCII; extended codes are never mapped.
    function automatic logic [7:0] map_ascii(input logic [7:0] code, input logic ext,
                                             input logic upper);
        logic [7:0] a;
        a = 8'h00;
        if (!ext) begin
            case (code)
                8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
                8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
                8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
                8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
                8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
                8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
                8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
                8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
                8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
                8'h3E: a = 8'h38; 8'h46: a = 8'h39;
                8'h29: a = 8'h20; 8'h5A: a = 8'h0D;
                default: a = 8'h00;
            endcase
        end
        if (upper && (a >= 8'h61) && (a <= 8'h7A)) begin
            a = a - 8'h20;
        end
        return a;
    endfunction

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (kbd_ready) state_d = POP;
            POP:     state_d = SETTLE;
            SETTLE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The pop strobe is decoded straight from the state so reset releases it at once.
    always_comb begin
        kbd_nextdata_n = (state_q != POP);
    end

    assign same_key = key_held_q && (held_code_q == byte_q) && (held_ext_q == ext_q);

    always_comb begin
        byte_d        = byte_q;
        ext_d         = ext_q;
        brk_d         = brk_q;
        key_code_d    = key_code_q;
        key_ext_d     = key_ext_q;
        key_ascii_d   = key_ascii_q;
        key_held_d    = key_held_q;
        key_event_d   = 1'b0;
        key_break_d   = key_break_q;
        press_count_d = press_count_q;
        held_code_d   = held_code_q;
        held_ext_d    = held_ext_q;
`ifdef PS2_SHIFT_EN
        shift_l_d     = shift_l_q;
        shift_r_d     = shift_r_q;
`endif
        if ((state_q == IDLE) && kbd_ready) begin
            byte_d = kbd_data;
        end
        if (state_q == POP) begin
            if (byte_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (byte_q == 8'hF0) begin
                brk_d = 1'b1;
`ifdef PS2_SHIFT_EN
            end else if ((byte_q == 8'h12) || (byte_q == 8'h59)) begin
                if (byte_q == 8'h12) shift_l_d = ~brk_q;
                else                 shift_r_d = ~brk_q;
                ext_d = 1'b0;
                brk_d = 1'b0;
`endif
            end else begin
                key_code_d  = byte_q;
                key_ext_d   = ext_q;
                key_break_d = brk_q;
                key_event_d = 1'b1;
                ext_d       = 1'b0;
                brk_d       = 1'b0;
                if (brk_q) begin
                    if (same_key) begin
                        key_held_d  = 1'b0;
                        key_ascii_d = 8'h00;
                    end
                end else if (!same_key) begin
                    key_held_d    = 1'b1;
                    held_code_d   = byte_q;
                    held_ext_d    = ext_q;
                    key_ascii_d   = map_ascii(byte_q, ext_q, shift_any);
                    press_count_d = press_count_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            byte_q        <= 8'h00;
            ext_q         <= 1'b0;
            brk_q         <= 1'b0;
            key_code_q    <= 8'h00;
            key_ext_q     <= 1'b0;
            key_ascii_q   <= 8'h00;
            key_held_q    <= 1'b0;
            key_event_q   <= 1'b0;
            key_break_q   <= 1'b0;
            press_count_q <= '0;
            held_code_q   <= 8'h00;
            held_ext_q    <= 1'b0;
`ifdef PS2_SHIFT_EN
            shift_l_q     <= 1'b0;
            shift_r_q     <= 1'b0;
`endif
        end else begin
            byte_q        <= byte_d;
            ext_q         <= ext_d;
            brk_q         <= brk_d;
            key_code_q    <= key_code_d;
            key_ext_q     <= key_ext_d;
            key_ascii_q   <= key_ascii_d;
            key_held_q    <= key_held_d;
            key_event_q   <= key_event_d;
            key_break_q   <= key_break_d;
            press_count_q <= press_count_d;
            held_code_q   <= held_code_d;
            held_ext_q    <= held_ext_d;
`ifdef PS2_SHIFT_EN
            shift_l_q     <= shift_l_d;
            shift_r_q     <= shift_r_d;
`endif
        end
    end

    assign key_code    = key_code_q;
    assign key_ext     = key_ext_q;
    assign key_ascii   = key_ascii_q;
    assign key_held    = key_held_q;
    assign key_event   = key_event_q;
    assign key_break   = key_break_q;
    assign press_count = press_count_q;

endmodule

// File: doc/ps2_scan_decoder.md
# ps2_scan_decoder

Consumes raw scan-code bytes from the PS/2 keyboard receiver FIFO and turns them into key events. Handles the E0 extended prefix and the F0 break prefix, tracks the currently held key, suppresses typematic repeats, maps make codes to ASCII, and counts distinct key presses. Its outputs drive the seven-segment and LED display logic downstream.

## Interface
- CNT_W, 8: width of the press counter.
- clk  in  1  system clock, rising edge.
- clrn  in  1  asynchronous active-low reset.
- kbd_data  in  8  scan byte at the receiver FIFO head; valid while kbd_ready=1.
- kbd_ready  in  1  FIFO non-empty.
- kbd_nextdata_n  out  1  active-low pop strobe to the FIFO; exactly one cycle per byte consumed.
- key_code  out  8  last non-prefix scan code processed.
- key_ext  out  1  key_code was preceded by E0.
- key_ascii  out  8  ASCII of the held key; 0x00 when no key is held or the code is unmapped.
- key_held  out  1  a key is currently held.
- key_event  out  1  one-cycle pulse for each processed make or break.
- key_break  out  1  qualifies key_event: 1 = release.
- press_count  out  CNT_W  count of new presses.

## Operation
- FSM states: IDLE, POP, SETTLE.
  - IDLE: if kbd_ready=1, latch kbd_data into byte_r, go to POP.
  - POP: kbd_nextdata_n=0 for this cycle only. Decode byte_r. Go to SETTLE.
  - SETTLE: kbd_nextdata_n=1. Wait one cycle so the registered FIFO ready/pointer updates, then go to IDLE.
- Decode of byte_r in POP:
  - 0xE0: set ext_f. No event.
  - 0xF0: set brk_f. No event.
  - Any other code: key_code<=byte, key_ext<=ext_f, key_break<=brk_f, pulse key_event. Clear ext_f and brk_f.
- Make when key_held=0, or when the code/ext differs from the held key: the new key becomes held, key_held=1, press_count+1. Wraps modulo 2^CNT_W.
- Make equal to the held key (typematic repeat): key_event pulses; no count change.
- Break of the held key: key_held=0, key_ascii=0x00.
- Break of a key that is not held: key_event pulses; held state unchanged.
- ASCII map (non-extended only):
  - Letters a–z, e.g. 0x1C→0x61, 0x32→0x62, 0x1A→0x7A.
  - Digits 0–9, e.g. 0x45→0x30, 0x16→0x31.
  - 0x29→0x20, 0x5A→0x0D.
  - Everything else, and every extended code, maps to 0x00.
- Prefix order F0 then E0 is accepted; both flags apply to the next non-prefix byte.

## Timing
- Reset values: kbd_nextdata_n=1, key_code=0, key_ext=0, key_ascii=0, key_held=0, key_event=0, key_break=0, press_count=0. FSM returns to IDLE and ext_f=brk_f=0.
- Reset asserted mid-handshake drops kbd_nextdata_n to 1 immediately (asynchronous). No partial pop survives.
- Latency: kbd_ready rising at edge N → kbd_nextdata_n low during cycle N+1.
- key_event and all updated outputs are registered and become valid at edge N+2.
- Throughput: one byte per 3 cycles. Back-to-back FIFO contents drain without gaps beyond SETTLE.
- kbd_nextdata_n is never low for two consecutive cycles.
- No pop is issued while kbd_ready=0.
- Outputs hold their values between events. key_event is high for exactly one cycle.

## Configuration
- PS2_SHIFT_EN defined:
  - Codes 0x12 and 0x59 set or clear a shift_l/shift_r latch on make/break. They generate no key_event, no count, and no held change.
  - While either shift latch is set, letters map to uppercase (0x1C→0x41).
  - Shift latches reset to 0.
- PS2_SHIFT_EN undefined:
  - 0x12 and 0x59 are ordinary unmapped keys: they become held, are counted, and give ascii 0x00.
  - Letters are always lowercase.

## Test plan
- Feed 0x1C → kbd_nextdata_n low one cycle; key_event=1, key_break=0, key_ascii=0x61, key_held=1, press_count=1.
- Feed 0x1C ×3 more (typematic repeat) → three key_event pulses; press_count stays 1. Then F0 1C → key_break=1, key_held=0, key_ascii=0x00.
- Feed E0 75 then E0 F0 75 → key_code=0x75, key_ext=1, ascii 0x00, count+1, then released. A following 0x75 alone reports key_ext=0.
- Preload 6 bytes (16 F0 16 45 F0 45) with kbd_ready held high → six single-cycle pops spaced 3 cycles apart; press_count=2; final key_held=0.
- With PS2_SHIFT_EN: 12, 1C → ascii 0x41, press_count=1; F0 12, F0 1C, 1C → ascii 0x61. Without it: 12 counts as a press, ascii 0x00.
- Assert clrn during POP → all outputs at reset values, kbd_nextdata_n=1 immediately; after release the next byte is processed normally.
